// File: rtl/ula.sv
// ula: 4-bit arithmetic/logic unit with a registered 8-bit result.
// One operation per clock, selected by switchs. Operands are zero-extended
// to 8 bits. Divide and modulo share one combinational restoring divider.
// A divide or modulo by zero returns 8'h00 and raises erro.

module ula (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] switchs,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] saida,
    output logic       erro
);

    // 4-bit restoring divider, returns {remainder, quotient}.
    // Only meaningful for a nonzero divisor. The caller masks the zero case.
    function automatic logic [7:0] div_restoring(input logic [3:0] dividend,
                                                 input logic [3:0] divisor);
        logic [4:0] rem_v;
        logic [3:0] quo_v;
        rem_v = 5'd0;
        quo_v = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            rem_v = {rem_v[3:0], dividend[i]};
            if (rem_v >= {1'b0, divisor}) begin
                rem_v    = rem_v - {1'b0, divisor};
                quo_v[i] = 1'b1;
            end else begin
                quo_v[i] = 1'b0;
            end
        end
        return {rem_v[3:0], quo_v};
    endfunction

    logic [7:0] a_ext_s;
    logic [7:0] b_ext_s;
    logic [7:0] divmod_s;
    logic [3:0] quo_s;
    logic [3:0] rem_s;
    logic       div_zero_s;
    logic [7:0] result_s;
    logic       erro_s;

    assign a_ext_s    = {4'b0000, A};
    assign b_ext_s    = {4'b0000, B};
    assign divmod_s   = div_restoring(A, B);
    assign quo_s      = divmod_s[3:0];
    assign rem_s      = divmod_s[7:4];
    assign div_zero_s = (B == 4'd0);

    // Next-result selection: every opcode produces an 8-bit value and error flag.
    always_comb begin
        result_s = 8'h00;
        erro_s   = 1'b0;
        case (switchs)
            4'b0000: result_s = a_ext_s + b_ext_s;
            4'b0001: result_s = a_ext_s - b_ext_s;
            4'b0010: result_s = a_ext_s * b_ext_s;
            4'b0011: begin
                if (div_zero_s) begin
                    result_s = 8'h00;
                    erro_s   = 1'b1;
                end else begin
                    result_s = {4'b0000, quo_s};
                    erro_s   = 1'b0;
                end
            end
            4'b0100: begin
                if (div_zero_s) begin
                    result_s = 8'h00;
                    erro_s   = 1'b1;
                end else begin
                    result_s = {4'b0000, rem_s};
                    erro_s   = 1'b0;
                end
            end
            4'b0101: result_s = {4'b0000, A & B};
            4'b0110: result_s = {4'b0000, A | B};
            4'b0111: result_s = {4'b0000, A ^ B};
            4'b1000: result_s = {4'b0000, ~A};
            4'b1001: result_s = a_ext_s << B[1:0];
            4'b1010: result_s = a_ext_s >> B[1:0];
            4'b1011: begin
                if (A > B) begin
                    result_s = 8'h01;
                end else if (A == B) begin
                    result_s = 8'h00;
                end else begin
                    result_s = 8'hFF;
                end
            end
            4'b1100: begin
                if (A >= B) begin
                    result_s = a_ext_s;
                end else begin
                    result_s = b_ext_s;
                end
            end
            4'b1101: begin
                if (A <= B) begin
                    result_s = a_ext_s;
                end else begin
                    result_s = b_ext_s;
                end
            end
            4'b1110: result_s = a_ext_s + 8'd1;
            4'b1111: result_s = b_ext_s;
            default: begin
                result_s = 8'h00;
                erro_s   = 1'b0;
            end
        endcase
    end

    // Output register: captures the selected result every cycle, cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida <= 8'h00;
            erro  <= 1'b0;
        end else begin
            saida <= result_s;
            erro  <= erro_s;
        end
    end

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula: directed vectors for each operation group,
// reset behaviour, one-cycle latency, an exhaustive sweep and random traffic,
// all checked against a plain-arithmetic reference model.

module tb_ula;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] switchs;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] saida;
    logic       erro;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       err;
    } vec_t;

    ula dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .switchs(switchs),
        .A      (A),
        .B      (B),
        .saida  (saida),
        .erro   (erro)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic, low 8 bits of the result, error in bit 8.
    function automatic logic [8:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        logic e;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        e  = 1'b0;
        case (op)
            4'd0:  r = ia + ib;
            4'd1:  r = ia - ib;
            4'd2:  r = ia * ib;
            4'd3:  if (ib == 0) e = 1'b1; else r = ia / ib;
            4'd4:  if (ib == 0) e = 1'b1; else r = ia % ib;
            4'd5:  r = int'(a & b);
            4'd6:  r = int'(a | b);
            4'd7:  r = int'(a ^ b);
            4'd8:  r = 15 - ia;
            4'd9:  r = ia * (1 << (ib % 4));
            4'd10: r = ia / (1 << (ib % 4));
            4'd11: r = (ia > ib) ? 1 : ((ia == ib) ? 0 : -1);
            4'd12: r = (ia > ib) ? ia : ib;
            4'd13: r = (ia < ib) ? ia : ib;
            4'd14: r = ia + 1;
            default: r = ib;
        endcase
        return {e, r[7:0]};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        switchs = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        switchs = 4'b0000;
        A = 4'd15;
        B = 4'd15;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #3;
            n_cmp++;
            if (saida !== 8'h00 || erro !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got saida=%h erro=%b, want 00 0", i, saida, erro);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (saida !== 8'h1E || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got saida=%h erro=%b, want 1e 0", saida, erro);
        end
    endtask

    task automatic test_reset_mid;
        drive(4'b0000, 4'd3, 4'd4);
        switchs = 4'b0000;
        A = 4'd9;
        B = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (saida !== 8'h00 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got saida=%h erro=%b, want 00 0", saida, erro);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (saida !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got saida=%h, want 00", saida);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (saida !== 8'h12 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got saida=%h erro=%b, want 12 0", saida, erro);
        end
    endtask

    task automatic test_add_sub;
        vec_t v[8] = '{
            '{4'h0, 4'd0, 4'd0, 8'h00, 1'b0}, '{4'h0, 4'd4, 4'd1, 8'h05, 1'b0},
            '{4'h0, 4'd8, 4'd15, 8'h17, 1'b0}, '{4'h0, 4'd15, 4'd15, 8'h1E, 1'b0},
            '{4'h1, 4'd8, 4'd4, 8'h04, 1'b0}, '{4'h1, 4'd2, 4'd3, 8'hFF, 1'b0},
            '{4'h1, 4'd1, 4'd4, 8'hFD, 1'b0}, '{4'h1, 4'd4, 4'd4, 8'h00, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (saida !== v[i].res || erro !== v[i].err) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: got saida=%h erro=%b, want %h %b", i, saida, erro, v[i].res, v[i].err);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v[4] = '{
            '{4'h2, 4'd8, 4'd0, 8'h00, 1'b0}, '{4'h2, 4'd8, 4'd8, 8'h40, 1'b0},
            '{4'h2, 4'd15, 4'd1, 8'h0F, 1'b0}, '{4'h2, 4'd15, 4'd15, 8'hE1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (saida !== v[i].res || erro !== v[i].err) begin
                n_fail++;
                $display("FAIL mul[%0d]: got saida=%h erro=%b, want %h %b", i, saida, erro, v[i].res, v[i].err);
            end
        end
    endtask

    task automatic test_divmod;
        vec_t v[8] = '{
            '{4'h3, 4'd8, 4'd2, 8'h04, 1'b0}, '{4'h3, 4'd2, 4'd2, 8'h01, 1'b0},
            '{4'h3, 4'd9, 4'd1, 8'h09, 1'b0}, '{4'h3, 4'd1, 4'd0, 8'h00, 1'b1},
            '{4'h4, 4'd9, 4'd4, 8'h01, 1'b0}, '{4'h3, 4'd9, 4'd3, 8'h03, 1'b0},
            '{4'h4, 4'd7, 4'd0, 8'h00, 1'b1}, '{4'h4, 4'd15, 4'd15, 8'h00, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (saida !== v[i].res || erro !== v[i].err) begin
                n_fail++;
                $display("FAIL divmod[%0d]: got saida=%h erro=%b, want %h %b", i, saida, erro, v[i].res, v[i].err);
            end
        end
    endtask

    task automatic test_logic;
        vec_t v[14] = '{
            '{4'h5, 4'd12, 4'd10, 8'h08, 1'b0}, '{4'h7, 4'd12, 4'd10, 8'h06, 1'b0},
            '{4'h8, 4'd5, 4'd0, 8'h0A, 1'b0},   '{4'h9, 4'd15, 4'd3, 8'h78, 1'b0},
            '{4'hA, 4'd8, 4'd2, 8'h02, 1'b0},   '{4'hB, 4'd3, 4'd7, 8'hFF, 1'b0},
            '{4'hB, 4'd7, 4'd7, 8'h00, 1'b0},   '{4'hE, 4'd15, 4'd0, 8'h10, 1'b0},
            '{4'h6, 4'd12, 4'd10, 8'h0E, 1'b0}, '{4'hB, 4'd9, 4'd2, 8'h01, 1'b0},
            '{4'hC, 4'd3, 4'd9, 8'h09, 1'b0},   '{4'hD, 4'd3, 4'd9, 8'h03, 1'b0},
            '{4'hF, 4'd1, 4'd10, 8'h0A, 1'b0},  '{4'h9, 4'd1, 4'd14, 8'h04, 1'b0}};
        for (int i = 0; i < 14; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if (saida !== v[i].res || erro !== v[i].err) begin
                n_fail++;
                $display("FAIL logic[%0d]: got saida=%h erro=%b, want %h %b", i, saida, erro, v[i].res, v[i].err);
            end
        end
    endtask

    task automatic test_latency;
        drive(4'b0000, 4'd1, 4'd2);
        n_cmp++;
        if (saida !== 8'h03) begin
            n_fail++;
            $display("FAIL latency_first: got saida=%h, want 03", saida);
        end
        A = 4'd5;
        #2;
        switchs = 4'b0011;
        B = 4'd0;
        #1;
        n_cmp++;
        if (saida !== 8'h03 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_hold: got saida=%h erro=%b, want 03 0", saida, erro);
        end
        switchs = 4'b0010;
        A = 4'd6;
        B = 4'd7;
        #4;
        n_cmp++;
        if (saida !== 8'h03) begin
            n_fail++;
            $display("FAIL latency_hold_late: got saida=%h, want 03", saida);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (saida !== 8'h2A || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_update: got saida=%h erro=%b, want 2a 0", saida, erro);
        end
    endtask

    task automatic test_sweep;
        logic [8:0] exp;
        for (int op = 0; op < 16; op++) begin
            for (int ab = 0; ab < 256; ab++) begin
                drive(op[3:0], ab[7:4], ab[3:0]);
                exp = model(op[3:0], ab[7:4], ab[3:0]);
                n_cmp++;
                if (saida !== exp[7:0] || erro !== exp[8]) begin
                    n_fail++;
                    $display("FAIL sweep op=%0d a=%0d b=%0d: got saida=%h erro=%b, want %h %b",
                             op, ab[7:4], ab[3:0], saida, erro, exp[7:0], exp[8]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [8:0] exp;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = 4'($urandom_range(15, 0));
            b  = 4'($urandom_range(15, 0));
            drive(op, a, b);
            exp = model(op, a, b);
            n_cmp++;
            if (saida !== exp[7:0] || erro !== exp[8]) begin
                n_fail++;
                $display("FAIL random op=%0d a=%0d b=%0d: got saida=%h erro=%b, want %h %b",
                         op, a, b, saida, erro, exp[7:0], exp[8]);
            end
            switchs = 4'($urandom_range(15, 0));
            A = 4'($urandom_range(15, 0));
            #2;
            n_cmp++;
            if (saida !== exp[7:0] || erro !== exp[8]) begin
                n_fail++;
                $display("FAIL random_hold[%0d]: got saida=%h erro=%b, want %h %b", i, saida, erro, exp[7:0], exp[8]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_mul;
        test_divmod;
        test_logic;
        test_latency;
        test_reset_mid;
        test_sweep;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ula.md
# ula

Small 4-bit arithmetic/logic unit with a registered 8-bit result. It computes one operation, selected by `switchs`, on unsigned 4-bit operands `A` and `B`. The result is captured on every rising clock edge. The block feeds a display or datapath stage that expects a stable result one cycle after the operands and opcode are applied.

## Interface
- No parameters; all widths fixed.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `switchs`  input  4  operation select (opcode).
- `A`  input  4  operand A, unsigned.
- `B`  input  4  operand B, unsigned.
- `saida`  output  8  registered result.
- `erro`  output  1  registered flag: high when the captured operation was a divide or modulo by zero.

## Operation
Operands are zero-extended to 8 bits before computing. The result is truncated to 8 bits where needed.

- `0000` add: A + B, range 0..30.
- `0001` subtract: A − B as 8-bit two's complement. Negative results wrap, e.g. 2 − 3 = 8'hFF and 1 − 4 = 8'hFD.
- `0010` multiply: A × B unsigned, range 0..225; 15 × 15 = 8'hE1.
- `0011` divide: floor(A / B) unsigned. If B = 0: result 8'h00 and `erro` = 1.
- `0100` modulo: A mod B. If B = 0: result 8'h00 and `erro` = 1.
- `0101` AND: {4'b0, A & B}.
- `0110` OR: {4'b0, A | B}.
- `0111` XOR: {4'b0, A ^ B}.
- `1000` NOT A: {4'b0, ~A}.
- `1001` shift left: A << B[1:0]. Zero-filled, result fits in 8 bits.
- `1010` shift right: A >> B[1:0], logical.
- `1011` compare: 8'h01 if A > B, 8'h00 if A == B, 8'hFF if A < B (−1).
- `1100` max(A, B), zero-extended.
- `1101` min(A, B), zero-extended.
- `1110` increment A: A + 1, range 1..16.
- `1111` pass B: {4'b0, B}.

Combinational rules:
- Division and modulo use a combinational 4-bit restoring divider. No iterative handshake is used.
- `erro` is 0 for every opcode other than `0011`/`0100` with B = 0.
- No other flags or status outputs exist.

## Timing
- Reset: asserting `rst_n` low clears `saida` to 8'h00 and `erro` to 0 immediately, without waiting for a clock edge. Both outputs hold those values while `rst_n` is low.
- Release: `rst_n` deasserts synchronously to `clk` by system convention. The first capture happens on the first rising edge with `rst_n` high.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on `saida`/`erro` right after edge N. The outputs hold until edge N+1.
- Throughput: one operation per cycle, no stall, no handshake. Changing `switchs`, `A` or `B` every cycle is legal.
- Input changes between edges do not affect the outputs. The outputs are glitch-free, driven only by flops.
- Reset mid-operation: any result not yet captured is lost. Outputs go to 0 at once.

## Test plan
- Reset: drive `rst_n` = 0 with opcode 0000, A = 15, B = 15, and toggle `clk` -> `saida` = 8'h00 and `erro` = 0 throughout. After release, the next edge gives `saida` = 8'h1E.
- Add/sub, one vector per cycle:
  - 0+0 -> 8'h00
  - 4+1 -> 8'h05
  - 8+15 -> 8'h17
  - 15+15 -> 8'h1E
  - 8−4 -> 8'h04
  - 2−3 -> 8'hFF
  - 1−4 -> 8'hFD
  - 4−4 -> 8'h00
- Multiply: 8×0 -> 8'h00; 8×8 -> 8'h40; 15×1 -> 8'h0F; 15×15 -> 8'hE1.
- Divide/modulo:
  - 8/2 -> 8'h04
  - 2/2 -> 8'h01
  - 9/1 -> 8'h09
  - 1/0 -> 8'h00 with `erro` = 1
  - 9 mod 4 -> 8'h01
  - next cycle 9/3 -> 8'h03 with `erro` back to 0
- Logic/shift/compare:
  - AND 12,10 -> 8'h08
  - XOR 12,10 -> 8'h06
  - NOT 5 -> 8'h0A
  - shl 15,3 -> 8'h78
  - shr 8,2 -> 8'h02
  - cmp 3,7 -> 8'hFF
  - cmp 7,7 -> 8'h00
  - inc 15 -> 8'h10
- Latency and back-to-back: change inputs mid-cycle -> `saida` unchanged until the next rising edge. Exhaustive sweep of all 16 opcodes × 256 operand pairs against a reference model, with a 1-cycle delay.
